extremal_search_sched: RTL

Frame-level sequencer for the extremal searcher register block (CTRL 0x0, STATUS 0x4, MAX_VAL 0x8, MAX_IDX 0xC) in the acoustic-camera power-map path. On each frame_start pulse it arms the searcher, polls it for completion with a timeout, and reads back the peak value and peak index. It then presents one result record with a threshold-hit flag. It sits between the beamformer frame timing and the searcher register port, replacing software polling from the PS.

---
 rtl/extremal_search_sched.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/extremal_search_sched.sv
// Frame-level sequencer for the extremal searcher: arms it, polls STATUS with a
// bounded retry count, reads MAX_VAL/MAX_IDX and publishes one result record per frame.
module extremal_search_sched #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0,
    parameter int POLL_GAP  = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] threshold,
    output logic              busy,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_max,
    output logic [DATA_W-1:0] res_idx,
    output logic              res_hit,
    output logic              res_timeout,
    output logic [7:0]        overrun_cnt,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic              reg_ack,
    input  logic [DATA_W-1:0] reg_rdata
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] ADDR_CTRL    = ADDR_W'(BASE_ADDR + 0);
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(BASE_ADDR + 4);
    localparam logic [ADDR_W-1:0] ADDR_MAX_VAL = ADDR_W'(BASE_ADDR + 8);
    localparam logic [ADDR_W-1:0] ADDR_MAX_IDX = ADDR_W'(BASE_ADDR + 12);

    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(POLL_GAP);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_POLL,
        S_RD_MAX,
        S_RD_IDX,
        S_CLR,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic                pending_reg;
    logic [DATA_W-1:0]   thr_reg;
    logic [GAP_W-1:0]    gap_reg;
    logic [CNT_W-1:0]    poll_cnt_reg;
    logic [DATA_W-1:0]   max_cap_reg;
    logic [DATA_W-1:0]   idx_cap_reg;
    logic                to_flag_reg;

    logic                busy_reg;
    logic                res_valid_reg;
    logic [DATA_W-1:0]   res_max_reg;
    logic [DATA_W-1:0]   res_idx_reg;
    logic                res_hit_reg;
    logic                res_timeout_reg;
    logic [7:0]          overrun_cnt_reg;
    logic                reg_req_reg;
    logic                reg_we_reg;
    logic [ADDR_W-1:0]   reg_addr_reg;
    logic [DATA_W-1:0]   reg_wdata_reg;

    logic                xfer;

    // An acknowledge only counts while a request is actually outstanding.
    assign xfer = reg_req_reg & reg_ack;

    assign busy        = busy_reg;
    assign res_valid   = res_valid_reg;
    assign res_max     = res_max_reg;
    assign res_idx     = res_idx_reg;
    assign res_hit     = res_hit_reg;
    assign res_timeout = res_timeout_reg;
    assign overrun_cnt = overrun_cnt_reg;
    assign reg_req     = reg_req_reg;
    assign reg_we      = reg_we_reg;
    assign reg_addr    = reg_addr_reg;
    assign reg_wdata   = reg_wdata_reg;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg       <= S_IDLE;
            pending_reg     <= 1'b0;
            thr_reg         <= '0;
            gap_reg         <= '0;
            poll_cnt_reg    <= '0;
            max_cap_reg     <= '0;
            idx_cap_reg     <= '0;
            to_flag_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_max_reg     <= '0;
            res_idx_reg     <= '0;
            res_hit_reg     <= 1'b0;
            res_timeout_reg <= 1'b0;
            overrun_cnt_reg <= '0;
            reg_req_reg     <= 1'b0;
            reg_we_reg      <= 1'b0;
            reg_addr_reg    <= '0;
            reg_wdata_reg   <= '0;
        end else begin
            res_valid_reg <= 1'b0;

            // One frame request may queue behind the running sequence; further ones are dropped.
            if (frame_start && (state_reg != S_IDLE)) begin
                if (!pending_reg) begin
                    pending_reg <= 1'b1;
                end else if (overrun_cnt_reg != 8'hFF) begin
                    overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    if (frame_start || pending_reg) begin
                        thr_reg       <= threshold;
                        pending_reg   <= frame_start & pending_reg;
                        to_flag_reg   <= 1'b0;
                        busy_reg      <= 1'b1;
                        reg_req_reg   <= 1'b1;
                        reg_we_reg    <= 1'b1;
                        reg_addr_reg  <= ADDR_CTRL;
                        reg_wdata_reg <= DATA_W'(1);
                        state_reg     <= S_ARM;
                    end
                end

                S_ARM: begin
                    if (xfer) begin
                        reg_req_reg  <= 1'b0;
                        gap_reg      <= GAP_LOAD;
                        poll_cnt_reg <= '0;
                        state_reg    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (gap_reg == '0) begin
                        reg_req_reg   <= 1'b1;
                        reg_we_reg    <= 1'b0;
                        reg_addr_reg  <= ADDR_STATUS;
                        reg_wdata_reg <= '0;
                        state_reg     <= S_POLL;
                    end else begin
                        gap_reg <= gap_reg - GAP_W'(1);
                    end
                end

                S_POLL: begin
                    if (xfer) begin
                        reg_req_reg <= 1'b0;
                        if (reg_rdata[0]) begin
                            state_reg <= S_RD_MAX;
                        end else if (poll_cnt_reg == POLL_LAST) begin
                            to_flag_reg <= 1'b1;
                            state_reg   <= S_CLR;
                        end else begin
                            poll_cnt_reg <= poll_cnt_reg + CNT_W'(1);
                            gap_reg      <= GAP_LOAD;
                            state_reg    <= S_WAIT;
                        end
                    end
                end

                // The remaining access states spend one idle cycle before raising the request.
                S_RD_MAX: begin
                    if (!reg_req_reg) begin
                        reg_req_reg   <= 1'b1;
                        reg_we_reg    <= 1'b0;
                        reg_addr_reg  <= ADDR_MAX_VAL;
                        reg_wdata_reg <= '0;
                    end else if (reg_ack) begin
                        reg_req_reg <= 1'b0;
                        max_cap_reg <= reg_rdata;
                        state_reg   <= S_RD_IDX;
                    end
                end

                S_RD_IDX: begin
                    if (!reg_req_reg) begin
                        reg_req_reg   <= 1'b1;
                        reg_we_reg    <= 1'b0;
                        reg_addr_reg  <= ADDR_MAX_IDX;
                        reg_wdata_reg <= '0;
                    end else if (reg_ack) begin
                        reg_req_reg <= 1'b0;
                        idx_cap_reg <= reg_rdata;
                        state_reg   <= S_CLR;
                    end
                end

                S_CLR: begin
                    if (!reg_req_reg) begin
                        reg_req_reg   <= 1'b1;
                        reg_we_reg    <= 1'b1;
                        reg_addr_reg  <= ADDR_CTRL;
                        reg_wdata_reg <= '0;
                    end else if (reg_ack) begin
                        reg_req_reg   <= 1'b0;
                        res_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                        // Results become visible together with the DONE pulse, not as reads land.
                        if (to_flag_reg) begin
                            res_timeout_reg <= 1'b1;
                            res_hit_reg     <= 1'b0;
                        end else begin
                            res_timeout_reg <= 1'b0;
                            res_max_reg     <= max_cap_reg;
                            res_idx_reg     <= idx_cap_reg;
                            res_hit_reg     <= (max_cap_reg >= thr_reg);
                        end
                    end
                end

                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    busy_reg    <= 1'b0;
                    reg_req_reg <= 1'b0;
                    state_reg   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
